// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine on a req/gnt/rvalid data bus.
// Runs one access at a time through IDLE -> REQ -> RESP -> DONE. Load data
// is extended and written back to the register file in DONE. Misaligned
// requests are rejected, and an access that stalls on the bus is aborted
// after TIMEOUT cycles.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_adr_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_adr_o,
    output logic [31:0] rf_wd_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned   TLAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic [29:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_rf_we;
    logic [4:0]    r_rf_adr;
    logic [31:0]   r_rf_wd;

    logic [2:0]    w_size;
    logic          w_aligned;
    logic          w_accept;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_lane;
    logic [31:0]   w_ext;
    logic          w_timeout;

    // Collapse the request size to B/H/W/BU/HU; anything unsupported acts as W
    always_comb begin
        w_size = F3_W;
        if (we_i) begin
            if (size_i == F3_B || size_i == F3_H) w_size = size_i;
        end else begin
            if (size_i == F3_B || size_i == F3_H || size_i == F3_BU || size_i == F3_HU)
                w_size = size_i;
        end
    end

    // Alignment check, lane enables and lane-replicated store data
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = wdata_i;
        case (w_size)
            F3_B, F3_BU: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                w_aligned = ~addr_i[0];
                w_be      = 4'b0011 << addr_i[1:0];
                w_wdata   = {2{wdata_i[15:0]}};
            end
            default: w_aligned = (addr_i[1:0] == 2'b00);
        endcase
    end

    // Shift the addressed lane down and extend it per the latched size
    always_comb begin
        w_lane = mem_rdata_i >> {r_off, 3'b000};
        case (r_size)
            F3_B:    w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_BU:   w_ext = {24'h0, w_lane[7:0]};
            F3_H:    w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_HU:   w_ext = {16'h0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    // Handshake status: stall, misalign pulse and timeout abort pulse
    always_comb begin
        w_accept   = (r_state == S_IDLE) && req_i && w_aligned;
        misalign_o = (r_state == S_IDLE) && req_i && !w_aligned;
        stall_o    = w_accept || (r_state == S_REQ) || (r_state == S_RESP);
        w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        bus_err_o  = w_timeout && (((r_state == S_REQ) && !mem_gnt_i) ||
                                   ((r_state == S_RESP) && !mem_rvalid_i));
    end

    // Access sequencer: latches the request, tracks bus handshakes and writeback
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_size   <= '0;
            r_off    <= '0;
            r_rd     <= '0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rf_we  <= 1'b0;
            r_rf_adr <= '0;
            r_rf_wd  <= '0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= we_i;
                        r_size  <= w_size;
                        r_off   <= addr_i[1:0];
                        r_rd    <= rd_adr_i;
                        r_addr  <= addr_i[31:2];
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid_i) begin
                        if (!r_we && (r_rd != '0)) begin
                            r_rf_we  <= 1'b1;
                            r_rf_adr <= r_rd;
                            r_rf_wd  <= w_ext;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_o   = (r_state == S_REQ);
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_addr_o  = {r_addr, 2'b00};
    assign mem_wdata_o = r_wdata;
    assign rf_we_o     = r_rf_we;
    assign rf_adr_o    = r_rf_adr;
    assign rf_wd_o     = r_rf_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table plus randomized accesses for the
// load/store unit, with a byte-level reference model and a small bus slave.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        nreset_i;
    logic        req_i;
    logic        we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_adr_i;
    logic        stall_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_adr_o;
    logic [31:0] rf_wd_o;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .nreset_i    (nreset_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rd_adr_i    (rd_adr_i),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .rf_we_o     (rf_we_o),
        .rf_adr_o    (rf_adr_o),
        .rf_wd_o     (rf_wd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        we;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        bit [31:0] rdata;
        int        gnt_dly;   // wait cycles before gnt; <0 = never
        int        rv_dly;    // RESP cycle carrying rvalid (1 = first)
        bit        spur;      // drive rvalid in REQ and gnt in RESP
        bit        mis;
        bit [31:0] maddr;
        bit [3:0]  be;
        bit [31:0] mwd;
        bit        rfwe;
        bit [31:0] rfwd;
        bit        berr;
    } vec_t;

    typedef struct {
        bit          mis;
        bit          done;
        bit          rfwe;
        bit          mwe;
        int          stall_cnt;
        int          berr_cnt;
        int          req_cnt;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [4:0]  rfadr;
        logic [31:0] rfwd;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit granted(vec_t v);
        return (v.gnt_dly >= 0) && (v.gnt_dly < TO);
    endfunction

    function automatic int req_cyc(vec_t v);
        return granted(v) ? v.gnt_dly + 1 : TO;
    endfunction

    function automatic int resp_cyc(vec_t v);
        if (!granted(v)) return 0;
        return (v.rv_dly <= TO) ? v.rv_dly : TO;
    endfunction

    // Reference model: works byte by byte from the access width and offset
    function automatic vec_t model(vec_t v);
        int     n;
        int     off;
        bit     sgn;
        longint val;
        off = int'(v.addr[1:0]);
        n   = 4;
        sgn = 1'b0;
        if (v.we) begin
            if (v.size == 3'd0) n = 1;
            else if (v.size == 3'd1) n = 2;
        end else begin
            case (v.size)
                3'd0: begin n = 1; sgn = 1'b1; end
                3'd1: begin n = 2; sgn = 1'b1; end
                3'd4: n = 1;
                3'd5: n = 2;
                default: n = 4;
            endcase
        end
        v.mis   = (off % n) != 0;
        v.maddr = {v.addr[31:2], 2'b00};
        v.be    = '0;
        v.mwd   = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) v.be[i] = 1'b1;
            v.mwd[8*i +: 8] = v.wdata[8*(i % n) +: 8];
        end
        val = 0;
        for (int j = 0; j < n; j++)
            if (off + j < 4) val = val | (longint'(v.rdata[8*(off+j) +: 8]) << (8*j));
        if (sgn && val >= (longint'(1) << (8*n - 1))) val = val - (longint'(1) << (8*n));
        v.rfwd = val[31:0];
        v.berr = !v.mis && (!granted(v) || v.rv_dly > TO);
        v.rfwe = !v.we && !v.mis && !v.berr && (v.rd != 5'd0);
        return v;
    endfunction

    function automatic vec_t mk(bit we, bit [2:0] sz, bit [31:0] a, bit [31:0] wd, int rd,
                                bit [31:0] rdata, int gd, int rv, bit spur, bit mis,
                                bit [3:0] be, bit [31:0] mwd, bit rfwe, bit [31:0] rfwd, bit berr);
        vec_t v;
        v.we = we; v.size = sz; v.addr = a; v.wdata = wd; v.rd = 5'(rd); v.rdata = rdata;
        v.gnt_dly = gd; v.rv_dly = rv; v.spur = spur;
        v.mis = mis; v.maddr = {a[31:2], 2'b00}; v.be = be; v.mwd = mwd;
        v.rfwe = rfwe; v.rfwd = rfwd; v.berr = berr;
        return v;
    endfunction

    // Core side plus bus slave for one access
    task automatic run_access(input vec_t v, output obs_t o);
        int req_seen;
        int resp_seen;
        bit gnt_done;
        bit fin;
        o = '{default: '0};
        @(negedge clk);
        req_i = 1'b1; we_i = v.we; size_i = v.size; addr_i = v.addr;
        wdata_i = v.wdata; rd_adr_i = v.rd;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = ~v.rdata;
        #1;
        o.mis = misalign_o;
        if (stall_o) o.stall_cnt++;
        if (misalign_o || !stall_o) begin
            req_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1;
                if (mem_req_o) o.req_cnt++;
                if (rf_we_o) o.rfwe = 1'b1;
                if (stall_o) o.stall_cnt++;
            end
            o.done = 1'b1;
            return;
        end
        req_seen = 0; resp_seen = 0; gnt_done = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = ~v.rdata;
            if (mem_req_o) begin
                req_seen++; o.req_cnt++;
                o.maddr = mem_addr_o; o.be = mem_be_o; o.mwd = mem_wdata_o; o.mwe = mem_we_o;
                mem_gnt_i    = (v.gnt_dly >= 0) && (req_seen == v.gnt_dly + 1);
                mem_rvalid_i = v.spur;
            end else if (gnt_done) begin
                resp_seen++;
                if (resp_seen == v.rv_dly) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = v.rdata;
                end
                mem_gnt_i = v.spur;
            end
            #1;
            if (bus_err_o) o.berr_cnt++;
            if (stall_o) begin
                o.stall_cnt++;
                if (mem_req_o && mem_gnt_i) gnt_done = 1'b1;
            end else begin
                fin = 1'b1; o.done = 1'b1;
                o.rfwe = rf_we_o; o.rfadr = rf_adr_o; o.rfwd = rf_wd_o;
                req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            end
        end
        req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o);
        chk({tag, " misalign"}, 32'(o.mis), 32'(v.mis));
        chk({tag, " done"}, 32'(o.done), 1);
        if (v.mis) begin
            chk({tag, " mis_req_cycles"}, o.req_cnt, 0);
            chk({tag, " mis_stall"}, o.stall_cnt, 0);
            chk({tag, " mis_rf_we"}, 32'(o.rfwe), 0);
        end else begin
            chk({tag, " stall_cycles"}, o.stall_cnt, 1 + req_cyc(v) + resp_cyc(v));
            chk({tag, " req_cycles"}, o.req_cnt, req_cyc(v));
            chk({tag, " bus_err"}, o.berr_cnt, 32'(v.berr));
            chk({tag, " mem_addr"}, o.maddr, v.maddr);
            chk({tag, " mem_be"}, 32'(o.be), 32'(v.be));
            chk({tag, " mem_we"}, 32'(o.mwe), 32'(v.we));
            if (v.we) chk({tag, " mem_wdata"}, o.mwd, v.mwd);
            chk({tag, " rf_we"}, 32'(o.rfwe), 32'(v.rfwe));
            if (v.rfwe) begin
                chk({tag, " rf_adr"}, 32'(o.rfadr), 32'(v.rd));
                chk({tag, " rf_wd"}, o.rfwd, v.rfwd);
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " stall"}, 32'(stall_o), 0);
        chk({tag, " misalign"}, 32'(misalign_o), 0);
        chk({tag, " bus_err"}, 32'(bus_err_o), 0);
        chk({tag, " mem_req"}, 32'(mem_req_o), 0);
        chk({tag, " mem_we"}, 32'(mem_we_o), 0);
        chk({tag, " mem_be"}, 32'(mem_be_o), 0);
        chk({tag, " mem_addr"}, mem_addr_o, 0);
        chk({tag, " mem_wdata"}, mem_wdata_o, 0);
        chk({tag, " rf_we"}, 32'(rf_we_o), 0);
        chk({tag, " rf_adr"}, 32'(rf_adr_o), 0);
        chk({tag, " rf_wd"}, rf_wd_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        obs_t o;
        bit [2:0] sizes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        nreset_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; addr_i = '0;
        wdata_i = '0; rd_adr_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        nreset_i = 1'b1;

        //          we sz   addr       wdata        rd rdata        gd  rv sp mis be       mwd          rfwe rfwd         berr
        tbl.push_back(mk(0, 3'd2, 32'h100, 32'h0,        5, 32'hDEADBEEF, 0,  1, 0, 0, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 3'd0, 32'h103, 32'h0,        3, 32'h80FFFF00, 0,  1, 0, 0, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 3'd4, 32'h103, 32'h0,        3, 32'h80FFFF00, 1,  2, 1, 0, 4'b1000, 32'h0,        1, 32'h00000080, 0));
        tbl.push_back(mk(0, 3'd1, 32'h102, 32'h0,        4, 32'h80010000, 0,  1, 0, 0, 4'b1100, 32'h0,        1, 32'hFFFF8001, 0));
        tbl.push_back(mk(1, 3'd0, 32'h201, 32'h12345678, 9, 32'h0,        0,  1, 0, 0, 4'b0010, 32'h78787878, 0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd2, 32'h102, 32'h0,        5, 32'h0,        0,  1, 0, 1, 4'b0000, 32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd2, 32'h104, 32'h0,        0, 32'h55AA55AA, 0,  1, 0, 0, 4'b1111, 32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd2, 32'h108, 32'h0,        6, 32'h11111111, -1, 1, 0, 0, 4'b1111, 32'h0,        0, 32'h0,        1));
        tbl.push_back(mk(0, 3'd5, 32'h102, 32'h0,        7, 32'h80010000, 0,  1, 0, 0, 4'b1100, 32'h0,        1, 32'h00008001, 0));
        tbl.push_back(mk(1, 3'd1, 32'h202, 32'hABCD1234, 0, 32'h0,        2,  3, 1, 0, 4'b1100, 32'h12341234, 0, 32'h0,        0));
        tbl.push_back(mk(1, 3'd2, 32'h300, 32'hCAFEF00D, 1, 32'h0,        0,  1, 0, 0, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd1, 32'h101, 32'h0,        2, 32'h0,        0,  1, 0, 1, 4'b0000, 32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd2, 32'h10C, 32'h0,        8, 32'h22222222, 0,  20, 0, 0, 4'b1111, 32'h0,       0, 32'h0,        1));
        tbl.push_back(mk(0, 3'd2, 32'h110, 32'h0,        10, 32'h33333333, 15, 1, 0, 0, 4'b1111, 32'h0,       1, 32'h33333333, 0));
        tbl.push_back(mk(0, 3'd2, 32'h110, 32'h0,        10, 32'h33333333, 16, 1, 0, 0, 4'b1111, 32'h0,       0, 32'h0,        1));
        tbl.push_back(mk(0, 3'd3, 32'h104, 32'h0,        11, 32'h11223344, 0,  1, 0, 0, 4'b1111, 32'h0,       1, 32'h11223344, 0));
        tbl.push_back(mk(1, 3'd4, 32'h101, 32'h0,        0, 32'h0,        0,  1, 0, 1, 4'b0000, 32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 3'd0, 32'h111, 32'h0,        12, 32'h00007F00, 0, 16, 0, 0, 4'b0010, 32'h0,       1, 32'h0000007F, 0));
        tbl.push_back(mk(0, 3'd0, 32'h111, 32'h0,        12, 32'h00007F00, 0, 17, 0, 0, 4'b0010, 32'h0,       0, 32'h0,        1));

        foreach (tbl[i]) begin
            run_access(tbl[i], o);
            compare($sformatf("tbl%0d", i), tbl[i], o);
        end

        // Reset while a load waits in RESP; the late rvalid must be dropped
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h400; rd_adr_i = 5'd7;
        @(negedge clk);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        #1;
        chk("rst_mid in_resp stall", 32'(stall_o), 1);
        req_i = 1'b0;
        nreset_i = 1'b0;
        @(negedge clk);
        nreset_i = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
            #1;
            chk($sformatf("rst_mid late_rvalid%0d stall", k), 32'(stall_o), 0);
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        chk("rst_mid late_rvalid rf_we", 32'(rf_we_o), 0);
        chk("rst_mid late_rvalid mem_req", 32'(mem_req_o), 0);

        for (int i = 0; i < 200; i++) begin
            v = '{default: '0};
            v.we      = 1'($urandom_range(1, 0));
            v.size    = sizes[$urandom_range(7, 0)];
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.rd      = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            v.gnt_dly = ($urandom_range(9, 0) == 0) ? int'($urandom_range(17, 14)) : int'($urandom_range(3, 0));
            v.rv_dly  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(18, 14)) : int'($urandom_range(4, 1));
            v.spur    = 1'($urandom_range(1, 0));
            v = model(v);
            run_access(v, o);
            compare($sformatf("rnd%0d", i), v, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
